// File: rtl/mult_share_arbiter.sv
// Shares one pipelined signed 9x33 multiplier between NREQ requesters.
// Round-robin issue (at most one op per cycle), a tag pipe that follows each
// op through the multiplier latency, and a one-deep result buffer per
// requester returned over a valid/ready handshake.
//
// Handshake semantics (both directions): a transfer happens on a rising clk
// edge where valid and ready are both high. A requester keeps req_valid and
// its operands stable until it sees req_ready. A result stays on rsp_valid and
// rsp_p, unchanged, until the edge where rsp_ready is high.
module mult_share_arbiter #(
    parameter int NREQ     = 4,
    parameter int MULT_LAT = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*9-1:0]   req_a,
    input  logic [NREQ*33-1:0]  req_b,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [NREQ*42-1:0]  rsp_p,
    output logic [8:0]          mult_a,
    output logic [32:0]         mult_b,
    output logic                mult_ce,
    output logic                mult_reset,
    input  logic [41:0]         mult_dout,
    output logic [3:0]          inflight
);
    // NREQ is at least 2, so the id is at least one bit wide.
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0] busy;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] rsp_hs;
    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic            grant_vld;
    int              cand;
    logic [8:0]      hold_a;
    logic [32:0]     hold_b;
    logic            tag_vld [MULT_LAT];
    logic [IDW-1:0]  tag_id  [MULT_LAT];

    assign rsp_hs  = rsp_valid & rsp_ready;
    assign mult_ce = en;

    // Round-robin pick: first eligible index after the pointer. Scanning from
    // the far end lets the nearest candidate overwrite the earlier ones.
    // Grants are suppressed while rst_n is low so req_ready reads 0 in reset.
    always_comb begin
        eligible  = req_valid & ~busy;
        grant_vld = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        cand      = 0;
        if (en && rst_n) begin
            for (int k = NREQ; k >= 1; k--) begin
                cand = (int'(rr_ptr) + k) % NREQ;
                if (eligible[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = IDW'(cand);
                end
            end
        end
        if (grant_vld) req_ready[grant_id] = 1'b1;
    end

    // Operand mux to the multiplier; idle cycles replay the last granted pair.
    always_comb begin
        mult_a = hold_a;
        mult_b = hold_b;
        if (grant_vld) begin
            mult_a = req_a[int'(grant_id)*9 +: 9];
            mult_b = req_b[int'(grant_id)*33 +: 33];
        end
    end

    // Remember the last issued operands for the idle-cycle replay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_a <= '0;
            hold_b <= '0;
        end else if (grant_vld) begin
            hold_a <= mult_a;
            hold_b <= mult_b;
        end
    end

    // One outstanding op per requester: busy from grant until its result is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= (busy & ~rsp_hs) | req_ready;
    end

    // Pointer moves to the winner only; starts at NREQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         rr_ptr <= IDW'(NREQ - 1);
        else if (grant_vld) rr_ptr <= grant_id;
    end

    // Tag pipe mirrors the multiplier pipeline and freezes with it when en=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < MULT_LAT; s++) begin
                tag_vld[s] <= 1'b0;
                tag_id[s]  <= '0;
            end
        end else if (en) begin
            tag_vld[0] <= grant_vld;
            tag_id[0]  <= grant_id;
            for (int s = 1; s < MULT_LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
        end
    end

    // Result buffers: clear on handshake, load when the tagged op leaves the
    // multiplier. busy guarantees the target buffer is already empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= '0;
            rsp_p     <= '0;
        end else begin
            rsp_valid <= rsp_valid & ~rsp_hs;
            if (en && tag_vld[MULT_LAT-1]) begin
                rsp_valid[tag_id[MULT_LAT-1]]                  <= 1'b1;
                rsp_p[int'(tag_id[MULT_LAT-1])*42 +: 42]       <= mult_dout;
            end
        end
    end

    // Multiplier sync reset held from async reset until the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mult_reset <= 1'b1;
        else        mult_reset <= 1'b0;
    end

    // Outstanding op count is simply the number of busy requesters.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < NREQ; i++) inflight = inflight + 4'(busy[i]);
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: a behavioural model of the Gowin multiplier,
// a cycle-level reference of the sharing rules, and a per-requester product
// scoreboard, plus directed scenarios.
module tb_mult_share_arbiter;
  localparam int NREQ = 4;
  localparam int LAT  = 3;  // accept cycle to rsp_valid cycle

  logic               clk;
  logic               rst_n;
  logic               en;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*9-1:0]  req_a;
  logic [NREQ*33-1:0] req_b;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ-1:0]    rsp_ready;
  logic [NREQ*42-1:0] rsp_p;
  logic [8:0]         mult_a;
  logic [32:0]        mult_b;
  logic               mult_ce;
  logic               mult_reset;
  logic [41:0]        mult_dout;
  logic [3:0]         inflight;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  mult_share_arbiter #(.NREQ(NREQ), .MULT_LAT(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .mult_a(mult_a), .mult_b(mult_b), .mult_ce(mult_ce), .mult_reset(mult_reset),
    .mult_dout(mult_dout), .inflight(inflight)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- multiplier model (input reg, output reg) ----------------
  logic signed [8:0]  ma_r;
  logic signed [32:0] mb_r;
  logic signed [41:0] mp_r;
  always @(posedge clk) begin
    if (mult_reset) begin
      ma_r <= '0; mb_r <= '0; mp_r <= '0;
    end else if (mult_ce) begin
      mp_r <= ma_r * mb_r;
      ma_r <= mult_a;
      mb_r <= mult_b;
    end
  end
  assign mult_dout = mp_r;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [41:0] prod42(input logic [8:0] a, input logic [32:0] b);
    longint pa, pb, p;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    p  = pa * pb;
    return p[41:0];
  endfunction

  // ---------------- reference model + expected queues ----------------
  logic [41:0]     exp_q [NREQ][$];
  logic [NREQ-1:0] m_busy;
  logic [NREQ-1:0] m_valid;
  logic [NREQ-1:0] exp_ready;
  int              m_ptr;
  int              m_age [NREQ];

  always @(negedge clk) begin
    int g;
    if (!rst_n) begin
      m_busy  = '0;
      m_valid = '0;
      m_ptr   = NREQ - 1;
      for (int i = 0; i < NREQ; i++) begin
        m_age[i] = 0;
        exp_q[i].delete();
      end
    end else begin
      g = -1;
      exp_ready = '0;
      if (en) begin
        for (int k = 1; k <= NREQ; k++) begin
          int idx;
          idx = (m_ptr + k) % NREQ;
          if (g < 0 && req_valid[idx] && !m_busy[idx]) g = idx;
        end
      end
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", req_ready, exp_ready);
      chk("rsp_valid", rsp_valid, m_valid);
      chk("inflight", inflight, $countones(m_busy));
      chk("mult_ce", mult_ce, en);
      for (int i = 0; i < NREQ; i++) begin
        if (m_valid[i] && rsp_ready[i]) begin
          m_busy[i]  = 1'b0;
          m_valid[i] = 1'b0;
        end else if (m_busy[i] && !m_valid[i] && en) begin
          m_age[i]++;
          if (m_age[i] == LAT) m_valid[i] = 1'b1;
        end
      end
      if (g >= 0) begin
        m_busy[g] = 1'b1;
        m_age[g]  = 1;
        m_ptr     = g;
        exp_q[g].push_back(prod42(req_a[9*g +: 9], req_b[33*g +: 33]));
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("rsp_unexpected", 64'(rsp_valid[i]), 64'd0);
          end else begin
            chk("rsp_p", rsp_p[42*i +: 42], exp_q[i][0]);
            if (rsp_ready[i]) void'(exp_q[i].pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Call at posedge+1; returns at posedge+1 of the following cycle.
  task automatic issue(input int id, input logic [8:0] a, input logic [32:0] b, output int acc);
    req_a[9*id +: 9]   = a;
    req_b[33*id +: 33] = b;
    req_valid[id]      = 1'b1;
    @(negedge clk);
    chk("issue_grant", 64'(req_ready[id]), 64'd1);
    acc = cyc;
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_rsp(input int id, input int acc, input int exp_lat, input logic [41:0] exp_p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rsp_valid[id] && n < 40);
    if (!rsp_valid[id]) begin
      chk("rsp_timeout", 64'(rsp_valid[id]), 64'd1);
    end else begin
      chk("rsp_latency", 64'(cyc - acc), 64'(exp_lat));
      chk("rsp_value", rsp_p[42*id +: 42], exp_p);
    end
  endtask

  task automatic rand_operands();
    for (int i = 0; i < NREQ; i++) begin
      req_a[9*i +: 9]   = 9'($urandom);
      req_b[33*i +: 33] = {1'($urandom_range(0, 1)), 32'($urandom)};
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc0, acc1, cnt1, cnt_other, pending;
    logic [8:0]  a0, a1;
    logic [32:0] b0, b1;

    rst_n = 1'b0; en = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_p", rsp_p[63:0], 0);
    chk("reset_inflight", inflight, 0);
    chk("reset_mult_reset", mult_reset, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_mult_reset_held", mult_reset, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mult_reset_cleared", mult_reset, 0);
    @(posedge clk); #1;

    // All four request together: round robin from requester 0.
    rand_operands();
    req_valid = '1;
    for (int c = 0; c < NREQ; c++) begin
      @(negedge clk);
      chk("t2_grant_order", req_ready, 64'(1 << c));
      @(posedge clk); #1;
      req_valid[c] = 1'b0;
    end
    idle(10);

    // Single op, exact latency and value.
    issue(0, 9'h1FD, 33'd1000, acc0);
    wait_rsp(0, acc0, LAT, 42'h3FF_FFFF_F448);
    idle(4);

    // Extreme operands.
    issue(2, 9'h100, 33'h1_0000_0000, acc0);
    wait_rsp(2, acc0, LAT, 42'h100_0000_0000);
    idle(4);
    issue(3, 9'h0FF, 33'h0_FFFF_FFFF, acc0);
    wait_rsp(3, acc0, LAT, 42'h0FE_FFFF_FF01);
    idle(4);

    // en low for 5 cycles with two ops in flight.
    a0 = 9'($urandom); b0 = 33'({$urandom, $urandom});
    a1 = 9'($urandom); b1 = 33'({$urandom, $urandom});
    issue(0, a0, b0, acc0);
    issue(1, a1, b1, acc1);
    en = 1'b0;
    req_valid = '1;
    repeat (5) begin
      @(negedge clk);
      chk("t4_no_grant", req_ready, 0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    en = 1'b1;
    wait_rsp(0, acc0, LAT + 5, prod42(a0, b0));
    wait_rsp(1, acc1, LAT + 5, prod42(a1, b1));
    idle(6);

    // Requester 1 stalls its result while everyone keeps requesting.
    cnt1 = 0; cnt_other = 0;
    rsp_ready = 4'b1101;
    req_valid = '1;
    for (int c = 0; c < 10; c++) begin
      rand_operands();
      @(negedge clk);
      if (req_ready[1]) cnt1++;
      if (req_ready != 0 && !req_ready[1]) cnt_other++;
      chk("t3_inflight_max", 64'(inflight <= 4'd4), 64'd1);
      @(posedge clk); #1;
    end
    chk("t3_req1_not_regranted", 64'(cnt1 <= 1), 64'd1);
    chk("t3_others_rotate", 64'(cnt_other >= 3), 64'd1);
    req_valid = '0;
    rsp_ready = '1;
    idle(8);

    // Random traffic checked by the model and scoreboard.
    for (int c = 0; c < 600; c++) begin
      en = ($urandom_range(0, 9) != 0);
      rand_operands();
      for (int i = 0; i < NREQ; i++) begin
        req_valid[i] = ($urandom_range(0, 99) < 55);
        rsp_ready[i] = ($urandom_range(0, 99) < 70);
      end
      @(posedge clk); #1;
    end
    en = 1'b1; rsp_ready = '1;
    idle(10);
    pending = 0;
    for (int i = 0; i < NREQ; i++) pending += exp_q[i].size();
    chk("drain_empty", 64'(pending), 64'd0);

    // Reset in the middle of two in-flight ops.
    issue(0, 9'($urandom), 33'($urandom), acc0);
    issue(1, 9'($urandom), 33'($urandom), acc1);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("t6_rsp_valid_in_reset", rsp_valid, 0);
    chk("t6_req_ready_in_reset", req_ready, 0);
    chk("t6_inflight_in_reset", inflight, 0);
    repeat (2) begin
      @(posedge clk);
    end
    #1;
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("t6_no_late_rsp", rsp_valid, 0);
      @(posedge clk); #1;
    end
    req_valid = '1;
    rand_operands();
    @(negedge clk);
    chk("t6_first_grant", req_ready, 64'b0001);
    @(posedge clk); #1;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "time limit");
  end

endmodule
